child_rr_scheduler: RTL and testbench

Round-robin scheduler that shares one downstream resource among the five child instances of a generated hierarchy level (instances 0..4). Each child raises a request; the scheduler grants exactly one owner at a time, holds the grant until release or a hold-limit timeout, and inserts a one-cycle turnaround gap between owners. It sits in the parent level, between the child instances and the shared resource.

---
 rtl/child_rr_scheduler.sv | 167 ++++++++++++++++
 tb/tb_child_rr_scheduler.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/child_rr_scheduler.sv
// ---------------------------------------------------------------------------
// child_rr_scheduler
//
// Shares one downstream resource among the N child instances of a generated
// hierarchy level. One child owns the resource at a time. The owner keeps the
// grant until it drops its request or until it has held the grant for
// MAX_HOLD cycles. A one-cycle gap with no owner separates consecutive
// owners. Arbitration is round-robin: the priority pointer moves to the
// index just after the previous owner.
//
// Parameters
//   N        number of requesters (2..16)
//   MAX_HOLD maximum consecutive grant cycles per owner (2..255)
//   IDW      width of grant_id
//
// Ports
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   req      per-child request level, held while the resource is wanted
//   en       per-child enable mask; a masked request is ignored
//   grant    registered one-hot grant; all zero when there is no owner
//   grant_id index of the current owner; keeps the last owner while idle
//   busy     high whenever grant is non-zero
//   preempt  one-cycle pulse in the gap cycle that follows a timeout
// ---------------------------------------------------------------------------
module child_rr_scheduler #(
    parameter int N        = 5,
    parameter int MAX_HOLD = 16,
    parameter int IDW      = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   en,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] grant_id,
    output logic           busy,
    output logic           preempt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);

    state_t          state;
    logic [IDW-1:0]  ptr;
    logic [7:0]      hold_cnt;

    logic [N-1:0]    ereq;
    logic            any_req;
    logic [IDW-1:0]  pick;
    logic            owner_req;

    // First index with an effective request, scanning upward from p and
    // wrapping at N. Only meaningful when r is non-zero.
    function automatic logic [IDW-1:0] rr_pick(input logic [N-1:0] r,
                                               input logic [IDW-1:0] p);
        logic [IDW-1:0] sel;
        logic           found;
        int             j;
        sel   = p;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = int'(p) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (!found && r[j]) begin
                sel   = IDW'(j);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    // Index following i, modulo N.
    function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] i);
        if (int'(i) >= N - 1) begin
            return '0;
        end
        return i + 1'b1;
    endfunction

    // One-hot decode of an owner index.
    function automatic logic [N-1:0] onehot(input logic [IDW-1:0] i);
        logic [N-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Hold counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

    assign ereq      = req & en;
    assign any_req   = |ereq;
    assign pick      = rr_pick(ereq, ptr);
    // grant_id always names the owner while in GRANT, so it doubles as the
    // owner register.
    assign owner_req = ereq[grant_id];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            grant    <= '0;
            grant_id <= '0;
            busy     <= 1'b0;
            preempt  <= 1'b0;
            ptr      <= '0;
            hold_cnt <= '0;
        end else begin
            case (state)
                S_IDLE, S_GAP: begin
                    // preempt only ever lives for the gap cycle after a timeout
                    preempt <= 1'b0;
                    if (any_req) begin
                        state    <= S_GRANT;
                        grant    <= onehot(pick);
                        grant_id <= pick;
                        busy     <= 1'b1;
                        hold_cnt <= 8'd1;
                    end else begin
                        state <= S_IDLE;
                        grant <= '0;
                        busy  <= 1'b0;
                    end
                end

                S_GRANT: begin
                    // A dropped request (or cleared enable) wins over the
                    // timeout, so a release on the last permitted cycle is
                    // never reported as a preemption.
                    if (!owner_req) begin
                        state   <= S_GAP;
                        grant   <= '0;
                        busy    <= 1'b0;
                        preempt <= 1'b0;
                        ptr     <= next_idx(grant_id);
                    end else if (hold_cnt == HOLD_LIM) begin
                        state   <= S_GAP;
                        grant   <= '0;
                        busy    <= 1'b0;
                        preempt <= 1'b1;
                        ptr     <= next_idx(grant_id);
                    end else begin
                        hold_cnt <= sat_inc(hold_cnt);
                        preempt  <= 1'b0;
                    end
                end

                default: begin
                    state   <= S_IDLE;
                    grant   <= '0;
                    busy    <= 1'b0;
                    preempt <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_child_rr_scheduler.sv
module tb_child_rr_scheduler;

    logic       clk;
    logic       rst_n;
    logic [4:0] req;
    logic [4:0] en;
    logic [4:0] grant;
    logic [2:0] grant_id;
    logic       busy;
    logic       preempt;

    child_rr_scheduler #(
        .N(5),
        .MAX_HOLD(16),
        .IDW(3)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req(req),
        .en(en),
        .grant(grant),
        .grant_id(grant_id),
        .busy(busy),
        .preempt(preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] cyc;
        logic [4:0]  g;
        logic [2:0]  id;
        logic        b;
        logic        p;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    cyc_count = 0;
    int    n_cmp = 0;
    int    n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req_v);
        n_cmp++;
        if (act !== req_v) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, req_v, $time);
        end
    endtask

    // Monitor: after every rising edge, compare the outputs against whatever
    // expectations are due for this cycle.
    initial begin
        exp_t  e;
        string nm;
        forever begin
            @(posedge clk);
            cyc_count++;
            #1;
            while (exp_q.size() > 0 && int'(exp_q[0].cyc) <= cyc_count) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                chk({nm, "/grant"},    32'(grant),    32'(e.g));
                chk({nm, "/grant_id"}, 32'(grant_id), 32'(e.id));
                chk({nm, "/busy"},     32'(busy),     32'(e.b));
                chk({nm, "/preempt"},  32'(preempt),  32'(e.p));
            end
        end
    end

    // Drive inputs for the next edge and queue the outputs expected after it.
    task automatic step(input logic [4:0] r, input logic [4:0] m,
                        input logic [4:0] g, input int id,
                        input logic b, input logic p, input string nm);
        exp_t e;
        req    = r;
        en     = m;
        e.cyc  = 32'(cyc_count + 1);
        e.g    = g;
        e.id   = 3'(id);
        e.b    = b;
        e.p    = p;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(negedge clk);
    endtask

    function automatic logic [4:0] oh(input int i);
        logic [4:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nxt;
        rst_n = 1'b0;
        req   = 5'b11111;
        en    = 5'b11111;
        @(negedge clk);

        // Reset holds everything at zero even with all requests raised
        step(5'b11111, 5'b11111, 5'b00000, 0, 0, 0, "rst0");
        step(5'b11111, 5'b11111, 5'b00000, 0, 0, 0, "rst1");
        rst_n = 1'b1;
        step(5'b11111, 5'b11111, 5'b00001, 0, 1, 0, "rst_rel");

        // Round robin: each owner holds 3 cycles, drops req one cycle
        for (int o = 0; o < 5; o++) begin
            nxt = (o + 1) % 5;
            step(5'b11111, 5'b11111, oh(o), o, 1, 0, $sformatf("rr%0d_h2", o));
            step(5'b11111, 5'b11111, oh(o), o, 1, 0, $sformatf("rr%0d_h3", o));
            step(5'b11111 & ~oh(o), 5'b11111, 5'b00000, o, 0, 0, $sformatf("rr%0d_gap", o));
            step(5'b11111, 5'b11111, oh(nxt), nxt, 1, 0, $sformatf("rr%0d_next", o));
        end

        // Timeout: only child 2 requests
        step(5'b00100, 5'b11111, 5'b00000, 0, 0, 0, "to_gap0");
        step(5'b00100, 5'b11111, 5'b00100, 2, 1, 0, "to_h1");
        for (int k = 2; k <= 16; k++)
            step(5'b00100, 5'b11111, 5'b00100, 2, 1, 0, $sformatf("to_h%0d", k));
        step(5'b00100, 5'b11111, 5'b00000, 2, 0, 1, "to_gap1");
        step(5'b00100, 5'b11111, 5'b00100, 2, 1, 0, "to2_h1");
        for (int k = 2; k <= 6; k++)
            step(5'b00100, 5'b11111, 5'b00100, 2, 1, 0, $sformatf("to2_h%0d", k));
        for (int k = 7; k <= 16; k++)
            step(5'b01100, 5'b11111, 5'b00100, 2, 1, 0, $sformatf("to2_h%0d", k));
        step(5'b01100, 5'b11111, 5'b00000, 2, 0, 1, "to_gap2");
        step(5'b01100, 5'b11111, 5'b01000, 3, 1, 0, "to_own3");

        // Mask: req=10110 en=00110, ptr moves to 4 after owner 3
        step(5'b10110, 5'b00110, 5'b00000, 3, 0, 0, "mask_gap");
        step(5'b10110, 5'b00110, 5'b00010, 1, 1, 0, "mask_own1");
        step(5'b10110, 5'b00110, 5'b00010, 1, 1, 0, "mask_h2");
        step(5'b10110, 5'b00110, 5'b00010, 1, 1, 0, "mask_h3");
        step(5'b10110, 5'b00100, 5'b00000, 1, 0, 0, "mask_enrel");
        step(5'b10110, 5'b00100, 5'b00100, 2, 1, 0, "mask_own2");

        // Wrap and skip, then idle
        step(5'b01000, 5'b11111, 5'b00000, 2, 0, 0, "wrap_gap2");
        step(5'b01000, 5'b11111, 5'b01000, 3, 1, 0, "wrap_own3");
        step(5'b00001, 5'b11111, 5'b00000, 3, 0, 0, "wrap_gap3");
        step(5'b00001, 5'b11111, 5'b00001, 0, 1, 0, "wrap_own0");
        step(5'b00000, 5'b11111, 5'b00000, 0, 0, 0, "idle_gap");
        step(5'b00000, 5'b11111, 5'b00000, 0, 0, 0, "idle0");
        step(5'b00000, 5'b11111, 5'b00000, 0, 0, 0, "idle1");

        // Reset mid-grant with ptr=4 and owner 3
        step(5'b11000, 5'b11111, 5'b01000, 3, 1, 0, "mr_own3a");
        step(5'b00000, 5'b11111, 5'b00000, 3, 0, 0, "mr_gap");
        step(5'b01000, 5'b11111, 5'b01000, 3, 1, 0, "mr_own3b");
        #2;
        req   = 5'b11000;
        rst_n = 1'b0;
        #1;
        chk("async_rst/grant",    32'(grant),    32'h0);
        chk("async_rst/busy",     32'(busy),     32'h0);
        chk("async_rst/grant_id", 32'(grant_id), 32'h0);
        chk("async_rst/preempt",  32'(preempt),  32'h0);
        #1;
        rst_n = 1'b1;
        step(5'b11000, 5'b11111, 5'b01000, 3, 1, 0, "mr_after");
        step(5'b00000, 5'b11111, 5'b00000, 3, 0, 0, "mr_rel");
        step(5'b00000, 5'b11111, 5'b00000, 3, 0, 0, "mr_idle");

        // Drain the scoreboard within a bounded number of cycles
        for (int w = 0; w < 20 && exp_q.size() > 0; w++)
            @(negedge clk);
        chk("drain/pending", 32'(exp_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
